// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
//
// Steps a one-hot "active stage" vector through an instruction sequence.
// A sequence starts from IDLE on start, walks bit 0 -> bit NUM_STAGES-1
// (one bit per cycle unless stalled or redirected by a jump), emits a
// one-cycle done pulse after the last stage and returns to IDLE. An abort
// or an illegal jump target ends the sequence early without a done pulse;
// the illegal-jump case also raises a sticky error flag.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin a sequence (honoured only in IDLE)
//   stall        hold the current stage for this cycle
//   jump         load jump_target instead of advancing
//   jump_target  one-hot next stage, NUM_STAGES wide
//   abort        terminate the running sequence immediately
//   stage        one-hot active stage, all-zero when not running
//   busy         high while running
//   done         one-cycle pulse on normal completion
//   error        sticky illegal-jump flag, cleared by the next accepted start
//   cycles       saturating count of running cycles of the current/last run
// ---------------------------------------------------------------------------
`ifndef NUM_STAGES
`define NUM_STAGES 6
`endif

module stage_sequencer #(
    parameter int NUM_STAGES = `NUM_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [NUM_STAGES-1:0] jump_target,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nx;
    logic [NUM_STAGES-1:0]   stage_nx;
    logic                    busy_nx;
    logic                    done_nx;
    logic                    error_nx;
    logic [7:0]              cycles_nx;
    logic [7:0]              cycles_inc;
    logic                    target_ok;

    // The cycle counter sticks at its maximum rather than wrapping, so a very
    // long stall still reads as "at least 255" instead of a small number.
    assign cycles_inc = (cycles == 8'hFF) ? cycles : cycles + 8'd1;

    // A jump is only meaningful when it names exactly one stage; zero or
    // several bits set means the stage mux feeding jump_target misbehaved.
    assign target_ok = $onehot(jump_target);

    // State and output register. All outputs come straight from flops so
    // downstream logic sees clean, glitch-free stage/busy/done signals.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            stage  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            cycles <= 8'd0;
        end else begin
            state  <= state_nx;
            stage  <= stage_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            error  <= error_nx;
            cycles <= cycles_nx;
        end
    end

    // Next-state logic. While running, the per-cycle priority is
    // abort > stall > jump > advance; every running cycle is counted,
    // including the one in which the sequence is aborted or fails a jump.
    // Leaving RUN from the last stage goes through DONE for exactly one cycle.
    always_comb begin
        state_nx  = state;
        stage_nx  = stage;
        error_nx  = error;
        cycles_nx = cycles;

        case (state)
            IDLE: begin
                stage_nx = '0;
                if (start) begin
                    state_nx  = RUN;
                    stage_nx  = FIRST_STAGE;
                    cycles_nx = 8'd0;
                    error_nx  = 1'b0;
                end
            end

            RUN: begin
                cycles_nx = cycles_inc;
                if (abort) begin
                    state_nx = IDLE;
                    stage_nx = '0;
                end else if (stall) begin
                    stage_nx = stage;
                end else if (jump) begin
                    if (target_ok) begin
                        stage_nx = jump_target;
                    end else begin
                        state_nx = IDLE;
                        stage_nx = '0;
                        error_nx = 1'b1;
                    end
                end else if (stage[NUM_STAGES-1]) begin
                    state_nx = DONE;
                    stage_nx = '0;
                end else begin
                    stage_nx = stage << 1;
                end
            end

            DONE: begin
                state_nx = IDLE;
                stage_nx = '0;
            end

            default: begin
                state_nx = IDLE;
                stage_nx = '0;
            end
        endcase

        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL take parameter NUM_STAGES, default the global `NUM_STAGES define (>=2); it is the width of every stage vector.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin an instruction sequence; honoured only in IDLE.
REQ-005 SHALL have port stall  input  1  hold the current stage for this cycle.
REQ-006 SHALL have port jump  input  1  load jump_target instead of advancing.
REQ-007 SHALL have port jump_target  input  NUM_STAGES  one-hot next stage, typically the output of a stage mux.
REQ-008 SHALL have port abort  input  1  terminate the sequence immediately.
REQ-009 SHALL have port stage  output  NUM_STAGES  one-hot active stage; all-zero when not running.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-012 SHALL have port error  output  1  sticky illegal-jump flag.
REQ-013 SHALL have port cycles  output  8  RUN cycle count of the current or most recent sequence.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; stage, busy and done are registered outputs.
REQ-015 In IDLE with start=1, SHALL enter RUN next cycle with stage=1 (bit 0), cycles=0, error cleared.
REQ-016 In IDLE with start=0, SHALL stay in IDLE with stage=0 and cycles held.
REQ-017 In RUN, per-cycle priority SHALL be abort > stall > jump > advance.
REQ-018 abort in RUN SHALL go to IDLE next cycle with stage=0, done=0, error unchanged.
REQ-019 stall in RUN SHALL hold stage; cycles still increments.
REQ-020 jump with a one-hot jump_target SHALL load stage=jump_target next cycle.
REQ-021 jump with jump_target zero or multi-hot SHALL set error=1, go to IDLE, stage=0, done=0.
REQ-022 Advance SHALL shift stage left one bit; from the MSB (last stage) it SHALL go to DONE with stage=0.
REQ-023 jump to the current stage SHALL be legal and equivalent to a one-cycle hold.
REQ-024 DONE SHALL last exactly one cycle with done=1, busy=0, then return to IDLE; start in DONE is ignored.
REQ-025 start while in RUN or DONE SHALL be ignored with no side effect.
REQ-026 cycles SHALL increment by 1 on every RUN cycle and saturate at 255, never wrap.
REQ-027 busy SHALL equal (state==RUN); stage SHALL be exactly one-hot whenever busy=1.
REQ-028 error SHALL remain set until the next accepted start or reset.
REQ-029 stall, jump, jump_target and abort SHALL be ignored outside RUN.

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE, stage=0, busy=0, done=0, error=0, cycles=0, overriding all other inputs.
REQ-031 reset asserted mid-RUN or in DONE SHALL abandon the sequence without a done pulse.

Verification (bench NUM_STAGES=6)
REQ-032 start one cycle, no other inputs -> stage 0x01,0x02,0x04,0x08,0x10,0x20 on consecutive cycles, then done=1 with stage=0, then IDLE; cycles=6.
REQ-033 Stall two cycles while stage=0x04 -> 0x04 held three cycles total, done 2 cycles later than REQ-032, cycles=8.
REQ-034 jump with target 0x20 while stage=0x02 -> next stage 0x20, then DONE; jump with target 0x06 -> error=1, stage=0, no done; next start clears error.
REQ-035 abort and jump together while stage=0x08 -> abort wins: stage=0, busy=0, done never pulses; start during RUN has no effect.
REQ-036 Stall held 300 cycles -> cycles saturates at 255; reset mid-stall -> all outputs zero the next cycle.
